spi_target_lite: RTL and testbench



---
 rtl/spi_target_pkg.sv | 12 +
 rtl/spi_target_rx_fifo.sv | 61 ++++++
 rtl/spi_target_lite.sv | 182 ++++++++++++++++++
 tb/tb_spi_target_lite.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and default sizing for the SPI mode-0 target.
package spi_target_pkg;

   localparam int unsigned DefCharLen = 8;
   localparam int unsigned DefRxDepth = 4;

   typedef enum logic {
      IDLE,
      SHIFT
   } spi_target_state_e;

endpackage

// File: rtl/spi_target_rx_fifo.sv
// Small RX FIFO with a registered head-of-queue output and registered full/empty flags.
module spi_target_rx_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_nxt  = ptr_inc(rd_ptr_q);
   assign cnt_d   = cnt_q + CntW'(do_push) - CntW'(do_pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         rdata    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (do_pop) rd_ptr_q <= rd_nxt;
         // Head register follows whatever entry becomes the oldest after this cycle.
         if (do_push && (empty || (do_pop && cnt_q == CntW'(1)))) begin
            rdata <= wdata;
         end else if (do_pop && cnt_q > CntW'(1)) begin
            rdata <= mem_q[rd_nxt];
         end
         cnt_q <= cnt_d;
         full  <= (cnt_d == CntW'(Depth));
         empty <= (cnt_d == '0);
      end
   end

endmodule

// File: rtl/spi_target_lite.sv
// Mode-0 SPI target oversampled in clk_i; RX/TX characters on valid/ready streams.
// Define SPI_TARGET_RX_FIFO_EN for an RxDepth-entry RX FIFO instead of a single holding register.
module spi_target_lite
   import spi_target_pkg::*;
#(
   parameter int unsigned CharLen = DefCharLen,
   parameter int unsigned RxDepth = DefRxDepth
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               ss_ni,
   input  logic               sclk_i,
   input  logic               sd_i,
   output logic               sd_o,
   output logic               sd_oe,
   output logic [CharLen-1:0] rx_data_o,
   output logic               rx_valid_o,
   input  logic               rx_ready_i,
   input  logic [CharLen-1:0] tx_data_i,
   input  logic               tx_valid_i,
   output logic               tx_ready_o,
   output logic               rx_overflow_o,
   output logic               tx_underrun_o
);

   localparam int unsigned CntW = $clog2(CharLen);

   if (CharLen < 2 || CharLen > 32) begin : g_bad_char_len
      $error("spi_target_lite: CharLen must be within 2..32");
   end
   if (RxDepth == 0 || (RxDepth & (RxDepth - 1)) != 0) begin : g_bad_rx_depth
      $error("spi_target_lite: RxDepth must be a power of two");
   end

   spi_target_state_e  state_q, state_d;
   logic [2:0]         ss_sync_q, sclk_sync_q;
   logic [1:0]         sd_sync_q;
   logic               ss_fall, ss_rise, rise, fall, sd_sync;
   logic [CntW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [CharLen-1:0] rx_shift_q, rx_shift_d, rx_char;
   logic [CharLen-1:0] tx_shift_q, tx_shift_d;
   logic [CharLen-1:0] hold_q;
   logic               tx_ready_q, tx_load, rx_push, rx_pop, rx_full;
   logic               sd_o_q, sd_oe_q, rx_overflow_q, tx_underrun_q;

   // Two-flop synchronisers plus a history flop for edge strobes; ss resets deselected.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ss_sync_q   <= 3'b111;
         sclk_sync_q <= '0;
         sd_sync_q   <= '0;
      end else begin
         ss_sync_q   <= {ss_sync_q[1:0], ss_ni};
         sclk_sync_q <= {sclk_sync_q[1:0], sclk_i};
         sd_sync_q   <= {sd_sync_q[0], sd_i};
      end
   end

   assign ss_fall = ss_sync_q[2] & ~ss_sync_q[1];
   assign ss_rise = ~ss_sync_q[2] & ss_sync_q[1];
   assign rise    = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign fall    = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign sd_sync = sd_sync_q[1];
   assign rx_char = {rx_shift_q[CharLen-2:0], sd_sync};
   assign rx_pop  = rx_valid_o & rx_ready_i;

   // Next-state and shift datapath.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      tx_load    = 1'b0;
      rx_push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            if (ss_fall) begin
               tx_load = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
            end else if (rise) begin
               rx_shift_d = rx_char;
               if (bit_cnt_q == CntW'(CharLen - 1)) begin
                  rx_push   = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CntW'(1);
               end
            end else if (fall) begin
               if (bit_cnt_q == '0) tx_load = 1'b1;
               else tx_shift_d = {tx_shift_q[CharLen-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase
      // An empty holding register (even one being written this cycle) sends zeros.
      if (tx_load) tx_shift_d = tx_ready_q ? '0 : hold_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         rx_shift_q    <= '0;
         tx_shift_q    <= '0;
         hold_q        <= '0;
         tx_ready_q    <= 1'b1;
         sd_o_q        <= 1'b0;
         sd_oe_q       <= 1'b0;
         tx_underrun_q <= 1'b0;
         rx_overflow_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         rx_shift_q    <= rx_shift_d;
         tx_shift_q    <= tx_shift_d;
         sd_oe_q       <= (state_d == SHIFT);
         sd_o_q        <= (state_d == SHIFT) & tx_shift_d[CharLen-1];
         tx_underrun_q <= tx_load & tx_ready_q;
         rx_overflow_q <= rx_push & rx_full & ~rx_pop;
         if (tx_load && !tx_ready_q) begin
            tx_ready_q <= 1'b1;
         end else if (tx_valid_i && tx_ready_q) begin
            hold_q     <= tx_data_i;
            tx_ready_q <= 1'b0;
         end
      end
   end

`ifdef SPI_TARGET_RX_FIFO_EN
   logic rx_empty;

   spi_target_rx_fifo #(
      .Width (CharLen),
      .Depth (RxDepth)
   ) u_rx_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .push   (rx_push),
      .wdata  (rx_char),
      .pop    (rx_pop),
      .rdata  (rx_data_o),
      .full   (rx_full),
      .empty  (rx_empty)
   );

   assign rx_valid_o = ~rx_empty;
`else
   logic [CharLen-1:0] rx_data_q;
   logic               rx_valid_q;

   // Single-entry RX holding register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else if (rx_push && (!rx_valid_q || rx_pop)) begin
         rx_data_q  <= rx_char;
         rx_valid_q <= 1'b1;
      end else if (rx_pop) begin
         rx_valid_q <= 1'b0;
      end
   end

   assign rx_full    = rx_valid_q;
   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_data_q;
`endif

   assign sd_o          = sd_o_q;
   assign sd_oe         = sd_oe_q;
   assign tx_ready_o    = tx_ready_q;
   assign rx_overflow_o = rx_overflow_q;
   assign tx_underrun_o = tx_underrun_q;

endmodule

// File: tb/tb_spi_target_lite.sv
// Directed bench: a behavioural mode-0 SPI host at 8x oversampling drives spi_target_lite.
module tb_spi_target_lite;

   localparam int HALF = 4;
   localparam int GAP  = 16;
`ifdef SPI_TARGET_RX_FIFO_EN
   localparam int ExpStored = 4;
   localparam int ExpOvf    = 2;
`else
   localparam int ExpStored = 1;
   localparam int ExpOvf    = 5;
`endif

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b0;
   logic       ss_ni = 1'b1;
   logic       sclk_i = 1'b0;
   logic       sd_i = 1'b0;
   logic       sd_o, sd_oe;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready_i = 1'b1;
   logic [7:0] tx_data_i = 8'h00;
   logic       tx_valid_i = 1'b0;
   logic       tx_ready_o, rx_overflow_o, tx_underrun_o;

   int         total = 0;
   int         bad = 0;
   int         und_cnt = 0;
   int         ovf_cnt = 0;
   logic [7:0] rx_got[$];

   spi_target_lite dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .ss_ni         (ss_ni),
      .sclk_i        (sclk_i),
      .sd_i          (sd_i),
      .sd_o          (sd_o),
      .sd_oe         (sd_oe),
      .rx_data_o     (rx_data_o),
      .rx_valid_o    (rx_valid_o),
      .rx_ready_i    (rx_ready_i),
      .tx_data_i     (tx_data_i),
      .tx_valid_i    (tx_valid_i),
      .tx_ready_o    (tx_ready_o),
      .rx_overflow_o (rx_overflow_o),
      .tx_underrun_o (tx_underrun_o)
   );

   always #5 clk_i = ~clk_i;

   // Pulse counters and RX pop capture, sampled mid-cycle.
   always @(negedge clk_i) begin
      if (tx_underrun_o) und_cnt++;
      if (rx_overflow_o) ovf_cnt++;
      if (rst_ni && rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk_i);
      #2;
   endtask

   task automatic tx_write(input logic [7:0] d);
      tx_data_i  = d;
      tx_valid_i = 1'b1;
      wait_cycles(1);
      tx_valid_i = 1'b0;
   endtask

   task automatic host_begin;
      ss_ni = 1'b0;
      wait_cycles(2 * HALF);
   endtask

   task automatic host_char(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      logic [7:0] sh;
      sh   = mosi;
      miso = '0;
      for (int b = 0; b < nbits; b++) begin
         sclk_i = 1'b0;
         sd_i   = sh[7];
         sh     = sh << 1;
         wait_cycles(HALF);
         miso   = {miso[6:0], sd_o};
         sclk_i = 1'b1;
         wait_cycles(HALF);
      end
   endtask

   task automatic host_end;
      ss_ni = 1'b1;
      wait_cycles(HALF);
      sclk_i = 1'b0;
      wait_cycles(GAP);
   endtask

   task automatic test_reset;
      wait_cycles(3);
      total++; if (sd_oe !== 1'b0)      begin bad++; $display("FAIL rst_sd_oe: got %b want 0", sd_oe); end
      total++; if (sd_o !== 1'b0)       begin bad++; $display("FAIL rst_sd_o: got %b want 0", sd_o); end
      total++; if (rx_valid_o !== 1'b0) begin bad++; $display("FAIL rst_rx_valid: got %b want 0", rx_valid_o); end
      total++; if (rx_data_o !== 8'h00) begin bad++; $display("FAIL rst_rx_data: got %h want 00", rx_data_o); end
      total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL rst_tx_ready: got %b want 1", tx_ready_o); end
      total++; if (rx_overflow_o !== 1'b0 || tx_underrun_o !== 1'b0) begin
         bad++; $display("FAIL rst_pulses: got ovf=%b und=%b want 0 0", rx_overflow_o, tx_underrun_o);
      end
      rst_ni = 1'b1;
      wait_cycles(GAP);
      total++; if (sd_oe !== 1'b0) begin bad++; $display("FAIL idle_sd_oe: got %b want 0", sd_oe); end
   endtask

   task automatic test_loopback;
      logic [7:0] r;
      int         und0;
      rx_got.delete();
      tx_write(8'hA5);
      total++; if (tx_ready_o !== 1'b0) begin bad++; $display("FAIL lb_hold_full: got %b want 0", tx_ready_o); end
      und0  = und_cnt;
      ss_ni = 1'b0;
      wait_cycles(2);
      total++; if (sd_oe !== 1'b0) begin bad++; $display("FAIL lb_oe_early: got %b want 0", sd_oe); end
      wait_cycles(1);
      total++; if (sd_oe !== 1'b1) begin bad++; $display("FAIL lb_oe_rise: got %b want 1", sd_oe); end
      total++; if (sd_o !== 1'b1)  begin bad++; $display("FAIL lb_first_bit: got %b want 1", sd_o); end
      total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL lb_hold_taken: got %b want 1", tx_ready_o); end
      wait_cycles(2 * HALF - 3);
      host_char(8'h3C, 8, r);
      host_end();
      total++; if (r !== 8'hA5) begin bad++; $display("FAIL lb_host_rx: got %h want a5", r); end
      total++; if (rx_got.size() != 1 || rx_got[0] !== 8'h3C) begin
         bad++; $display("FAIL lb_target_rx: got n=%0d first=%h want n=1 3c", rx_got.size(),
                         (rx_got.size() > 0) ? rx_got[0] : 8'hxx);
      end
      total++; if (und_cnt - und0 != 0) begin bad++; $display("FAIL lb_underrun: got %0d want 0", und_cnt - und0); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] r0, r1;
      int         k;
      logic       timed_out;
      int         und0;
      rx_got.delete();
      tx_write(8'h55);
      und0      = und_cnt;
      timed_out = 1'b0;
      fork
         begin
            host_begin();
            host_char(8'h01, 8, r0);
            host_char(8'h80, 8, r1);
            host_end();
         end
         begin
            k = 0;
            while (!tx_ready_o && k < 200) begin wait_cycles(1); k++; end
            if (tx_ready_o) tx_write(8'hAA);
            else timed_out = 1'b1;
         end
      join
      total++; if (timed_out) begin bad++; $display("FAIL b2b_tx_ready_wait: got timeout want ready"); end
      total++; if (r0 !== 8'h55 || r1 !== 8'hAA) begin
         bad++; $display("FAIL b2b_host_rx: got %h %h want 55 aa", r0, r1);
      end
      total++; if (rx_got.size() != 2 || rx_got[0] !== 8'h01 || rx_got[1] !== 8'h80) begin
         bad++; $display("FAIL b2b_target_rx: got n=%0d want 2 chars 01 80", rx_got.size());
      end
      total++; if (und_cnt - und0 != 0) begin bad++; $display("FAIL b2b_underrun: got %0d want 0", und_cnt - und0); end
   endtask

   task automatic test_underrun;
      logic [7:0] r0, r1;
      int         und0;
      rx_got.delete();
      und0 = und_cnt;
      host_begin();
      host_char(8'h96, 8, r0);
      host_char(8'h69, 8, r1);
      host_end();
      total++; if (r0 !== 8'h00 || r1 !== 8'h00) begin
         bad++; $display("FAIL und_host_rx: got %h %h want 00 00", r0, r1);
      end
      total++; if (und_cnt - und0 != 2) begin bad++; $display("FAIL und_pulses: got %0d want 2", und_cnt - und0); end
      total++; if (rx_got.size() != 2 || rx_got[0] !== 8'h96 || rx_got[1] !== 8'h69) begin
         bad++; $display("FAIL und_target_rx: got n=%0d want 2 chars 96 69", rx_got.size());
      end
   endtask

   task automatic test_overflow;
      logic [7:0] r;
      logic [7:0] exp_c;
      int         ovf0;
      rx_got.delete();
      rx_ready_i = 1'b0;
      ovf0 = ovf_cnt;
      host_begin();
      exp_c = 8'h11;
      for (int c = 0; c < 6; c++) begin
         host_char(exp_c, 8, r);
         exp_c = exp_c + 8'h11;
      end
      host_end();
      total++; if (ovf_cnt - ovf0 != ExpOvf) begin
         bad++; $display("FAIL ovf_pulses: got %0d want %0d", ovf_cnt - ovf0, ExpOvf);
      end
      total++; if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h11) begin
         bad++; $display("FAIL ovf_head: got v=%b d=%h want 1 11", rx_valid_o, rx_data_o);
      end
      rx_ready_i = 1'b1;
      wait_cycles(GAP);
      total++; if (rx_got.size() != ExpStored) begin
         bad++; $display("FAIL ovf_stored: got %0d want %0d", rx_got.size(), ExpStored);
      end
      exp_c = 8'h11;
      for (int i = 0; i < rx_got.size(); i++) begin
         total++; if (rx_got[i] !== exp_c) begin
            bad++; $display("FAIL ovf_order[%0d]: got %h want %h", i, rx_got[i], exp_c);
         end
         exp_c = exp_c + 8'h11;
      end
   endtask

   task automatic test_abort;
      logic [7:0] r;
      rx_got.delete();
      host_begin();
      host_char(8'hF0, 5, r);
      ss_ni = 1'b1;
      wait_cycles(2);
      total++; if (sd_oe !== 1'b1) begin bad++; $display("FAIL abort_oe_hold: got %b want 1", sd_oe); end
      wait_cycles(1);
      total++; if (sd_oe !== 1'b0) begin bad++; $display("FAIL abort_oe_drop: got %b want 0", sd_oe); end
      wait_cycles(HALF - 3);
      sclk_i = 1'b0;
      wait_cycles(GAP);
      total++; if (rx_got.size() != 0) begin bad++; $display("FAIL abort_no_push: got %0d want 0", rx_got.size()); end
      total++; if (r !== 8'h00) begin bad++; $display("FAIL abort_host_rx: got %h want 00", r); end
      host_begin();
      host_char(8'hC3, 8, r);
      host_end();
      total++; if (rx_got.size() != 1 || rx_got[0] !== 8'hC3) begin
         bad++; $display("FAIL abort_next_frame: got n=%0d want 1 char c3", rx_got.size());
      end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] r;
      host_begin();
      tx_write(8'h5A);
      host_char(8'h3C, 4, r);
      total++; if (sd_oe !== 1'b1 || tx_ready_o !== 1'b0 || rx_data_o !== 8'hC3) begin
         bad++; $display("FAIL mid_pre: got oe=%b rdy=%b rx=%h want 1 0 c3", sd_oe, tx_ready_o, rx_data_o);
      end
      rst_ni = 1'b0;
      #1;
      total++; if (sd_oe !== 1'b0 || sd_o !== 1'b0) begin
         bad++; $display("FAIL mid_sd: got oe=%b o=%b want 0 0", sd_oe, sd_o);
      end
      total++; if (tx_ready_o !== 1'b1) begin bad++; $display("FAIL mid_tx_ready: got %b want 1", tx_ready_o); end
      total++; if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h00) begin
         bad++; $display("FAIL mid_rx: got v=%b d=%h want 0 00", rx_valid_o, rx_data_o);
      end
      total++; if (rx_overflow_o !== 1'b0 || tx_underrun_o !== 1'b0) begin
         bad++; $display("FAIL mid_pulses: got ovf=%b und=%b want 0 0", rx_overflow_o, tx_underrun_o);
      end
      ss_ni  = 1'b1;
      sclk_i = 1'b0;
      wait_cycles(2);
      rst_ni = 1'b1;
      wait_cycles(GAP);
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_back_to_back();
      test_underrun();
      test_overflow();
      test_abort();
      test_reset_midframe();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
